seq_mag_comp: RTL and testbench

//  Parametrised, multi-cycle magnitude comparator for wide operands. Compares A and B one DIGIT-bit slice
//  per cycle, MSB slice first, with optional early exit on the first differing slice.

---
 rtl/magcomp_pkg.sv | 21 ++
 rtl/mag_comp_slice.sv | 27 ++
 rtl/seq_mag_comp.sv | 131 +++++++++++++
 tb/tb_seq_mag_comp.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/magcomp_pkg.sv
// Shared types and elaboration helpers for the sequential magnitude comparator.
package magcomp_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    // Smallest legal counter width, so a single-slice build still has a 1-bit index.
    localparam int MIN_IDX_W = 1;

    function automatic int ndig(input int width, input int digit);
        return (digit < 1) ? 1 : width / digit;
    endfunction

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : MIN_IDX_W;
    endfunction

endpackage

// File: rtl/mag_comp_slice.sv
// Combinational DIGIT-bit magnitude compare; the most significant differing bit decides.
module mag_comp_slice #(
    parameter int DIGIT = 4
) (
    input  logic [DIGIT-1:0] a_s,
    input  logic [DIGIT-1:0] b_s,
    output logic             eq,
    output logic             gt,
    output logic             lt
);

    logic above_eq;

    // NOTE: always_comb assigns every output before the loop so no path can infer a latch.
    always_comb begin
        above_eq = 1'b1;
        gt       = 1'b0;
        lt       = 1'b0;
        for (int i = DIGIT - 1; i >= 0; i--) begin
            gt       = gt | (above_eq & a_s[i] & ~b_s[i]);
            lt       = lt | (above_eq & ~a_s[i] & b_s[i]);
            above_eq = above_eq & ~(a_s[i] ^ b_s[i]);
        end
        eq = above_eq;
    end

endmodule

// File: rtl/seq_mag_comp.sv
// Multi-cycle magnitude comparator: scans DIGIT-bit slices MSB first, with optional early exit.
module seq_mag_comp
    import magcomp_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter int DIGIT      = 4,
    parameter int EARLY_EXIT = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             signed_mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             both_equal,
    output logic             a_greater,
    output logic             b_greater
);

    localparam int NDIG  = ndig(WIDTH, DIGIT);
    localparam int IDX_W = idx_width(NDIG);
    localparam logic [IDX_W-1:0] LAST     = IDX_W'(NDIG - 1);
    localparam logic [WIDTH-1:0] MSB_MASK = WIDTH'(1) << (WIDTH - 1);

    if (DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_bad_params
        $error("seq_mag_comp: WIDTH (%0d) must be a positive multiple of DIGIT (%0d)", WIDTH, DIGIT);
    end

    state_t           state;
    logic [WIDTH-1:0] opa;
    logic [WIDTH-1:0] opb;
    logic [IDX_W-1:0] idx;
    logic             decided;
    logic             dec_gt;

    logic [DIGIT-1:0] a_sl [NDIG];
    logic [DIGIT-1:0] b_sl [NDIG];
    logic             sl_eq;
    logic             sl_gt;
    logic             sl_lt;
    logic             accept;
    logic [WIDTH-1:0] flip;

    // Slice 0 is the most significant digit, so the index counts up as the scan proceeds.
    always_comb begin
        for (int i = 0; i < NDIG; i++) begin
            a_sl[i] = opa[WIDTH-1-i*DIGIT -: DIGIT];
            b_sl[i] = opb[WIDTH-1-i*DIGIT -: DIGIT];
        end
    end

    mag_comp_slice #(.DIGIT(DIGIT)) u_slice (
        .a_s (a_sl[idx]),
        .b_s (b_sl[idx]),
        .eq  (sl_eq),
        .gt  (sl_gt),
        .lt  (sl_lt)
    );

    assign accept = start && (state != RUN);
    // Flipping the sign bit maps two's complement onto an unsigned order (offset binary).
    assign flip   = signed_mode ? MSB_MASK : '0;

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            busy       <= 1'b0;
            done       <= 1'b0;
            both_equal <= 1'b0;
            a_greater  <= 1'b0;
            b_greater  <= 1'b0;
            idx        <= '0;
            opa        <= '0;
            opb        <= '0;
            decided    <= 1'b0;
            dec_gt     <= 1'b0;
        end else begin
            done <= 1'b0;
            if (accept) begin
                state      <= RUN;
                busy       <= 1'b1;
                opa        <= a ^ flip;
                opb        <= b ^ flip;
                idx        <= '0;
                decided    <= 1'b0;
                dec_gt     <= 1'b0;
                both_equal <= 1'b0;
                a_greater  <= 1'b0;
                b_greater  <= 1'b0;
            end else begin
                case (state)
                    RUN: begin
                        if (EARLY_EXIT != 0 && !sl_eq) begin
                            a_greater <= sl_gt;
                            b_greater <= sl_lt;
                            state     <= DONE;
                            busy      <= 1'b0;
                            done      <= 1'b1;
                        end else if (idx == LAST) begin
                            // The earliest (most significant) difference wins over later slices.
                            if (decided) begin
                                a_greater <= dec_gt;
                                b_greater <= !dec_gt;
                            end else if (sl_eq) begin
                                both_equal <= 1'b1;
                            end else begin
                                a_greater <= sl_gt;
                                b_greater <= sl_lt;
                            end
                            state <= DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end else begin
                            idx <= idx + 1'b1;
                            if (!decided && !sl_eq) begin
                                decided <= 1'b1;
                                dec_gt  <= sl_gt;
                            end
                        end
                    end
                    DONE:    state <= IDLE;
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_seq_mag_comp.sv
// Drives an early-exit and a full-scan comparator in lockstep against an arithmetic reference.
module tb_seq_mag_comp;

    localparam int WIDTH = 32;
    localparam int DIGIT = 4;
    localparam int NDIG  = WIDTH / DIGIT;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic             signed_mode;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;

    logic busy_e, done_e, eq_e, agt_e, bgt_e;
    logic busy_f, done_f, eq_f, agt_f, bgt_f;

    int checks   = 0;
    int failures = 0;

    seq_mag_comp #(.WIDTH(WIDTH), .DIGIT(DIGIT), .EARLY_EXIT(1)) dut_ee (
        .clk(clk), .rst(rst), .start(start), .signed_mode(signed_mode), .a(a), .b(b),
        .busy(busy_e), .done(done_e), .both_equal(eq_e), .a_greater(agt_e), .b_greater(bgt_e)
    );

    seq_mag_comp #(.WIDTH(WIDTH), .DIGIT(DIGIT), .EARLY_EXIT(0)) dut_full (
        .clk(clk), .rst(rst), .start(start), .signed_mode(signed_mode), .a(a), .b(b),
        .busy(busy_f), .done(done_f), .both_equal(eq_f), .a_greater(agt_f), .b_greater(bgt_f)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // {equal, a_greater, b_greater} straight from integer comparison.
    function automatic logic [2:0] ref_result(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv,
                                              input logic sm);
        logic signed [WIDTH-1:0] sa = av;
        logic signed [WIDTH-1:0] sb = bv;
        if (av == bv) return 3'b100;
        if (sm) return (sa > sb) ? 3'b010 : 3'b001;
        return (av > bv) ? 3'b010 : 3'b001;
    endfunction

    // Cycles from the accepting edge to the done cycle.
    function automatic int ref_latency(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv,
                                       input bit ee);
        logic [WIDTH-1:0] x    = av ^ bv;
        logic [WIDTH-1:0] mask = (WIDTH'(1) << DIGIT) - 1;
        if (!ee) return NDIG;
        for (int k = 0; k < NDIG; k++)
            if (((x >> ((NDIG - 1 - k) * DIGIT)) & mask) != 0) return k + 1;
        return NDIG;
    endfunction

    task automatic launch(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv, input logic sm);
        @(negedge clk);
        a = av; b = bv; signed_mode = sm; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        a = $urandom; b = $urandom; signed_mode = ~sm;
    endtask

    // Called 1 time unit after the accepting edge; waits out both DUTs with a fixed cycle budget.
    task automatic wait_done(input string tag, input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv,
                             input logic sm, input bit inject);
        int         lat_e = ref_latency(av, bv, 1'b1);
        int         lat_f = ref_latency(av, bv, 1'b0);
        logic [2:0] r     = ref_result(av, bv, sm);
        int         at_e  = -1;
        int         at_f  = -1;
        int         n_e   = 0;
        int         n_f   = 0;
        check({tag, ".busy0_ee"}, busy_e, 1'b1);
        check({tag, ".busy0_full"}, busy_f, 1'b1);
        for (int c = 1; c <= NDIG + 3; c++) begin
            if (inject && c == 3) begin
                start = 1'b1; a = ~av; b = av; signed_mode = ~sm;
            end else begin
                start = 1'b0;
            end
            @(posedge clk); #1;
            if (done_e) begin n_e++; if (at_e < 0) at_e = c; end
            if (done_f) begin n_f++; if (at_f < 0) at_f = c; end
        end
        check({tag, ".lat_ee"}, at_e, lat_e);
        check({tag, ".lat_full"}, at_f, lat_f);
        check({tag, ".pulses_ee"}, n_e, 1);
        check({tag, ".pulses_full"}, n_f, 1);
        check({tag, ".res_ee"}, {eq_e, agt_e, bgt_e}, r);
        check({tag, ".res_full"}, {eq_f, agt_f, bgt_f}, r);
        check({tag, ".idle_busy"}, {busy_e, busy_f}, 2'b00);
    endtask

    task automatic run_txn(input string tag, input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv,
                           input logic sm, input bit inject);
        launch(av, bv, sm);
        wait_done(tag, av, bv, sm, inject);
    endtask

    initial begin
        logic [WIDTH-1:0] ra, rb;
        logic [WIDTH-1:0] mask;
        int               n_done;

        rst = 1'b0; start = 1'b0; signed_mode = 1'b0; a = '0; b = '0;
        #1 rst = 1'b1;
        #1;
        check("reset_ee", {busy_e, done_e, eq_e, agt_e, bgt_e}, 5'b0);
        check("reset_full", {busy_f, done_f, eq_f, agt_f, bgt_f}, 5'b0);
        @(negedge clk); rst = 1'b0;

        run_txn("msb_diff", 32'h8000_0000, 32'h7FFF_FFFF, 1'b0, 1'b0);
        run_txn("equal", 32'h1234_5678, 32'h1234_5678, 1'b0, 1'b0);
        run_txn("neg1_vs_1_signed", 32'hFFFF_FFFF, 32'h0000_0001, 1'b1, 1'b0);
        run_txn("neg1_vs_1_unsigned", 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
        run_txn("msb_vs_zero", 32'h8000_0000, 32'h0000_0000, 1'b0, 1'b0);
        run_txn("min_vs_zero_signed", 32'h8000_0000, 32'h0000_0000, 1'b1, 1'b0);
        run_txn("lsb_diff_ignored_start", 32'h0000_0001, 32'h0000_0002, 1'b0, 1'b1);

        // Abort mid-scan: outputs clear at once and no done pulse follows.
        launch(32'h0000_0005, 32'h0000_0006, 1'b0);
        repeat (2) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("abort_ee", {busy_e, done_e, eq_e, agt_e, bgt_e}, 5'b0);
        check("abort_full", {busy_f, done_f, eq_f, agt_f, bgt_f}, 5'b0);
        @(negedge clk); rst = 1'b0;
        n_done = 0;
        for (int c = 0; c < NDIG + 2; c++) begin
            @(posedge clk); #1;
            if (done_e || done_f || busy_e || busy_f) n_done++;
        end
        check("abort_quiet", n_done, 0);
        run_txn("after_abort", 32'h0000_0005, 32'h0000_0005, 1'b0, 1'b0);

        // Restart in the DONE cycle: accepted, results cleared, new result follows.
        launch(32'hABCD_0000, 32'hABCD_0000, 1'b0);
        for (int c = 1; c < NDIG; c++) begin
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
        check("b2b_done", {done_e, done_f, eq_e, eq_f}, 4'b1111);
        a = 32'h0000_0010; b = 32'h0000_0020; signed_mode = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("b2b_cleared_ee", {busy_e, done_e, eq_e, agt_e, bgt_e}, 5'b10000);
        check("b2b_cleared_full", {busy_f, done_f, eq_f, agt_f, bgt_f}, 5'b10000);
        wait_done("b2b_second", 32'h0000_0010, 32'h0000_0020, 1'b0, 1'b0);

        // Random operands, biased toward equal values and single-digit differences.
        mask = (WIDTH'(1) << DIGIT) - 1;
        for (int i = 0; i < 24; i++) begin
            ra = $urandom;
            case ($urandom_range(0, 2))
                0:       rb = $urandom;
                1:       rb = ra;
                default: rb = ra ^ ((WIDTH'($urandom_range(1, 15)) & mask)
                                    << (DIGIT * $urandom_range(0, NDIG - 1)));
            endcase
            run_txn($sformatf("rand%0d", i), ra, rb, 1'($urandom_range(0, 1)), 1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
